axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI4-Lite-style memory responder: the far end of the EXU/LSU `mem_r`/`mem_w` master ports.
- Serves one outstanding read and one outstanding write at a time, each with a fixed programmable latency.
- Word-organised SRAM with byte strobes; used as the data-memory model behind the load/store unit and as a test-bench target.

Parameters:
ADDR_BASE, 32'h8000_0000, byte address of word 0
DEPTH_LOG2, 12, log2 of word count (default 4096 words = 16 KiB)
R_LAT, 2, idle cycles between AR handshake and rvalid (0..15)
W_LAT, 2, idle cycles between last of AW/W handshake and bvalid (0..15)

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
araddr  in  32  read byte address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data word
rresp  out  2  00 OKAY, 11 DECERR
rvalid  out  1  read data valid
rready  in  1  master accepts read data
awaddr  in  32  write byte address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte enables, bit i -> wdata[8i+7:8i]
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  00 OKAY, 11 DECERR
bvalid  out  1  write response valid
bready  in  1  master accepts write response

Behaviour:
- Interface: one clock (`clock`); `reset` synchronous, active-high, sampled on posedge `clock`.
- Reset:
  - Both FSMs return to IDLE; all counters and flags clear.
  - arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0 on the first cycle after reset drops.
  - SRAM array is not reset and keeps its contents.
  - Reset mid-transaction drops pending responses silently.
- Address decode:
  - Word index = (addr - ADDR_BASE)[DEPTH_LOG2+1:2]; addr[1:0] ignored.
  - In range iff ADDR_BASE <= addr < ADDR_BASE + 4<<DEPTH_LOG2; otherwise DECERR.
- Read FSM, states R_IDLE / R_WAIT / R_RESP:
  - R_IDLE:
    - arready=1.
    - On arvalid: latch address, load cnt=R_LAT, go to R_WAIT (or R_RESP directly if R_LAT=0).
  - R_WAIT:
    - cnt decrements each cycle.
    - At cnt==1, go to R_RESP and register rdata and rresp at that edge.
    - Out-of-range reads give rdata=0, rresp=11.
  - R_RESP:
    - rvalid=1; rdata and rresp held stable until rready.
    - On rvalid&rready, go to R_IDLE.
    - arready is 0 in this state; no AR/R overlap.
  - Timing: AR handshake at cycle t -> rvalid first high at t+1+R_LAT.
- Write FSM, states W_IDLE / W_WAIT / W_RESP:
  - W_IDLE:
    - awready = ~aw_got; wready = ~w_got.
    - AW and W are accepted in any order or in the same cycle, each latched once.
    - When both are held (including same-cycle capture), load cnt=W_LAT and go to W_WAIT (W_RESP if W_LAT=0).
  - Write commit:
    - Happens on the edge entering W_RESP; only bytes with wstrb bit set are written.
    - Out-of-range writes commit nothing; bresp=11.
  - W_RESP:
    - bvalid=1 until bready; then clear aw_got/w_got and go to W_IDLE.
  - Timing: last of AW/W handshake at cycle t -> bvalid first high at t+1+W_LAT.
- Read/write interaction:
  - The two FSMs are fully independent.
  - If a read samples the same word on the same edge a write commits, the read returns the pre-write data.
- Valid/ready rules:
  - arready, awready, wready do not depend combinationally on arvalid, awvalid, wvalid.
  - rvalid and bvalid never drop without the matching ready.

Test Plan:
- Reset, then write 32'hDEADBEEF, wstrb=4'hF to 32'h8000_0010 with AW and W in the same cycle -> bvalid at t+3, bresp=00; read 32'h8000_0010 -> rvalid at t+3, rdata=32'hDEADBEEF, rresp=00.
- W two cycles before AW, wstrb=4'b0101, wdata=32'h11223344 over the previous word -> later read returns 32'hDE22BE44; wready=0 while waiting for AW.
- Read 32'h7FFF_FFFC and write to 32'h8000_4000 -> rresp=11 with rdata=0, bresp=11; read back of word 0 unchanged.
- rready held low 5 cycles with rvalid high -> rdata stable, arready=0; a new arvalid is not accepted until the R handshake completes.
- Read and write to the same word timed so the read sample and write commit share an edge -> read returns old value; a subsequent read returns the new value.
- Assert reset while in R_WAIT and W_RESP -> next cycle rvalid=0, bvalid=0, arready=awready=wready=1; a previously written word still reads back correctly.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4-Lite-style word SRAM responder with byte strobes and fixed programmable
// read/write latencies; one outstanding read and one outstanding write.
module axi_sram_slave #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          R_LAT      = 2,
  parameter int          W_LAT      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  // Valid/ready: a beat transfers on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid holds until ready.

  localparam int          DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN   = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  R_LAT4 = 4'(R_LAT);
  localparam logic [3:0]  W_LAT4 = 4'(W_LAT);

  logic [31:0] mem [0:DEPTH-1];

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  r_state_t    r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;

  w_state_t    w_state;
  logic [3:0]  w_cnt;
  logic        aw_got;
  logic        w_got;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  // Read decode: in IDLE the live address is used so R_LAT=0 can sample at
  // the handshake edge.
  logic [31:0] rd_addr;
  logic [31:0] rd_off;
  logic        rd_hit;
  logic [DEPTH_LOG2-1:0] rd_idx;

  always_comb begin
    rd_addr = (r_state == R_IDLE) ? araddr : r_addr;
    rd_off  = rd_addr - ADDR_BASE;
    rd_hit  = ({1'b0, rd_off} < SPAN);
    rd_idx  = rd_off[DEPTH_LOG2+1:2];
  end

  // Write operands merge latched and same-cycle beats.
  logic [31:0] eff_addr;
  logic [31:0] eff_data;
  logic [3:0]  eff_strb;
  logic [31:0] wr_off;
  logic        wr_hit;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic        aw_take;
  logic        w_take;
  logic        both;
  logic        commit;

  always_comb begin
    eff_addr = aw_got ? w_addr : awaddr;
    eff_data = w_got ? w_data : wdata;
    eff_strb = w_got ? w_strb : wstrb;
    wr_off   = eff_addr - ADDR_BASE;
    wr_hit   = ({1'b0, wr_off} < SPAN);
    wr_idx   = wr_off[DEPTH_LOG2+1:2];
    aw_take  = awvalid && awready;
    w_take   = wvalid && wready;
    both     = (w_state == W_IDLE) && (aw_got || aw_take) && (w_got || w_take);
    commit   = !reset && (((w_state == W_IDLE) && both && (W_LAT == 0)) ||
                          ((w_state == W_WAIT) && (w_cnt == 4'd1)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= 32'd0;
      rresp   <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_addr  <= araddr;
          r_cnt   <= R_LAT4;
          arready <= 1'b0;
          if (R_LAT == 0) begin
            r_state <= R_RESP;
            rvalid  <= 1'b1;
            rdata   <= rd_hit ? mem[rd_idx] : 32'd0;
            rresp   <= rd_hit ? 2'b00 : 2'b11;
          end else begin
            r_state <= R_WAIT;
          end
        end
        R_WAIT: if (r_cnt == 4'd1) begin
          r_state <= R_RESP;
          rvalid  <= 1'b1;
          rdata   <= rd_hit ? mem[rd_idx] : 32'd0;
          rresp   <= rd_hit ? 2'b00 : 2'b11;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        R_RESP: if (rready) begin
          r_state <= R_IDLE;
          rvalid  <= 1'b0;
          arready <= 1'b1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_cnt   <= 4'd0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      w_addr  <= 32'd0;
      w_data  <= 32'd0;
      w_strb  <= 4'd0;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_take) begin
            w_addr  <= awaddr;
            aw_got  <= 1'b1;
            awready <= 1'b0;
          end
          if (w_take) begin
            w_data <= wdata;
            w_strb <= wstrb;
            w_got  <= 1'b1;
            wready <= 1'b0;
          end
          if (both) begin
            w_cnt <= W_LAT4;
            if (W_LAT == 0) begin
              w_state <= W_RESP;
              bvalid  <= 1'b1;
              bresp   <= wr_hit ? 2'b00 : 2'b11;
            end else begin
              w_state <= W_WAIT;
            end
          end
        end
        W_WAIT: if (w_cnt == 4'd1) begin
          w_state <= W_RESP;
          bvalid  <= 1'b1;
          bresp   <= wr_hit ? 2'b00 : 2'b11;
        end else begin
          w_cnt <= w_cnt - 4'd1;
        end
        W_RESP: if (bready) begin
          w_state <= W_IDLE;
          bvalid  <= 1'b0;
          aw_got  <= 1'b0;
          w_got   <= 1'b0;
          awready <= 1'b1;
          wready  <= 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // SRAM array carries no reset; a same-edge read sees the pre-write word.
  always_ff @(posedge clock) begin
    if (commit && wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_strb[b]) mem[wr_idx][8*b +: 8] <= eff_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave against a word-array reference model.
module tb_axi_sram_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DL2 = 12;
  localparam int RL  = 2;
  localparam int WL  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  axi_sram_slave #(.ADDR_BASE(BASE), .DEPTH_LOG2(DL2), .R_LAT(RL), .W_LAT(WL)) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    longint la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && (la < lb + 4 * (longint'(1) << DL2));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (!addr_ok(a)) return 32'd0;
    if (model.exists(widx(a))) return model[widx(a)];
    return 32'd0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!addr_ok(a)) return;
    w = model.exists(widx(a)) ? model[widx(a)] : 32'd0;
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model[widx(a)] = w;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    logic [31:0] ed;
    logic [31:0] er;
    int n, lat;
    ed = exp_rdata(a);
    er = addr_ok(a) ? 32'd0 : 32'd3;
    @(negedge clock);
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 100) begin @(negedge clock); n++; end
    check("ar_accept", 32'(n < 100), 32'd1);
    @(negedge clock);
    arvalid = 1'b0; lat = 1;
    while (!rvalid && lat < 100) begin @(negedge clock); lat++; end
    check("r_latency", lat, 1 + RL);
    check("rdata", rdata, ed);
    check("rresp", 32'(rresp), er);
    for (int i = 0; i < hold; i++) begin
      arvalid = 1'b1; araddr = BASE;
      @(negedge clock);
      check("r_hold_rvalid", 32'(rvalid), 32'd1);
      check("r_hold_rdata", rdata, ed);
      check("r_hold_arready", 32'(arready), 32'd0);
    end
    arvalid = 1'b0;
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
    check("r_done_rvalid", 32'(rvalid), 32'd0);
    check("r_done_arready", 32'(arready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_d, input int w_d, input int bdelay);
    int c, lat;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [31:0] er;
    er = addr_ok(a) ? 32'd0 : 32'd3;
    c = 0; aw_done = 0; w_done = 0;
    @(negedge clock);
    while (!(aw_done && w_done) && c < 200) begin
      if (!aw_done && c >= aw_d) begin awvalid = 1'b1; awaddr = a; end
      if (!w_done && c >= w_d) begin wvalid = 1'b1; wdata = d; wstrb = s; end
      if (w_done && !aw_done) check("wready_wait_aw", 32'(wready), 32'd0);
      if (aw_done && !w_done) check("awready_wait_w", 32'(awready), 32'd0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clock);
      c++;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  wvalid = 1'b0;  end
    end
    check("aw_w_accept", 32'(c < 200), 32'd1);
    lat = 1;
    while (!bvalid && lat < 100) begin @(negedge clock); lat++; end
    check("b_latency", lat, 1 + WL);
    check("bresp", 32'(bresp), er);
    model_write(a, d, s);
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clock);
      check("b_hold_bvalid", 32'(bvalid), 32'd1);
    end
    bready = 1'b1;
    @(negedge clock);
    bready = 1'b0;
    check("b_done_bvalid", 32'(bvalid), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_arready"}, 32'(arready), 32'd1);
    check({tag, "_awready"}, 32'(awready), 32'd1);
    check({tag, "_wready"},  32'(wready),  32'd1);
    check({tag, "_rvalid"},  32'(rvalid),  32'd0);
    check({tag, "_bvalid"},  32'(bvalid),  32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_idle_outputs("reset");
    check("reset_rdata", rdata, 32'd0);
    check("reset_rresp", 32'(rresp), 32'd0);
    check("reset_bresp", 32'(bresp), 32'd0);

    // Full write then readback, AW and W together.
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(32'h8000_0010, 0);
    // W leads AW by two cycles, partial strobe.
    do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, 2, 0, 1);
    do_read(32'h8000_0012, 0);
    check("merge_model", exp_rdata(32'h8000_0010), 32'hDE22_BE44);
    // Out-of-range on both sides; word 0 must be untouched.
    do_write(BASE, 32'h1234_5678, 4'hF, 1, 0, 0);
    do_read(32'h7FFF_FFFC, 0);
    do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 1, 2);
    do_read(BASE, 0);
    // Master stalls R for five cycles.
    do_read(32'h8000_0010, 5);
    // Same-edge read sample and write commit.
    fork
      do_read(32'h8000_0020, 0);
      do_write(32'h8000_0020, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    join
    fork
      do_read(32'h8000_0010, 0);
      do_write(32'h8000_0010, 32'h0BAD_CAFE, 4'hF, 0, 0, 0);
    join
    do_read(32'h8000_0010, 0);

    // Reset with write in W_RESP and read in R_WAIT.
    @(negedge clock);
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    wdata = 32'h5A5A_A5A5; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clock);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (WL) @(negedge clock);
    check("pre_reset_bvalid", 32'(bvalid), 32'd1);
    model_write(32'h8000_0030, 32'h5A5A_A5A5, 4'hF);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(negedge clock);
    arvalid = 1'b0;
    check("pre_reset_rvalid", 32'(rvalid), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle_outputs("midreset");
    do_read(32'h8000_0030, 0);
    do_read(BASE, 0);

    // Randomized traffic over a small word pool plus out-of-range addresses.
    for (int i = 0; i < 16; i++)
      do_write(BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 64))
                                        : BASE + 32'h4000 + 32'(4 * $urandom_range(0, 64));
      else
        a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15));
      a[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      end else begin
        do_read(a, $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
